// File: rtl/lane_striper_n.sv
// Time-slotted word striper: one lane slot per clk_2f cycle, walking the enabled lanes of a
// per-round latched mask; sync_in restarts at the first enabled lane of the incoming mask.
module lane_striper_n #(
    parameter int DATA_W = 32,
    parameter int LANES  = 4
) (
    input  logic                      clk_2f,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         data_input,
    input  logic                      valid_in,
    input  logic [LANES-1:0]          lane_mask,
    input  logic                      sync_in,
    output logic [LANES*DATA_W-1:0]   lane_data,
    output logic [LANES-1:0]          valid_out,
    output logic                      round_done,
    output logic [LANES-1:0]          mask_active
);

    localparam int PTR_W = $clog2(LANES);

    logic [PTR_W-1:0] ptr;
    logic [LANES-1:0] mask_q;

    logic [PTR_W-1:0] in_low;
    logic [PTR_W-1:0] in_high;
    logic [PTR_W-1:0] in_next;
    logic             in_any;
    logic [PTR_W-1:0] q_high;
    logic [PTR_W-1:0] q_next;
    logic             q_any;
    logic             q_has_next;

    logic             slot_act;
    logic             load_mask;
    logic             rd_nxt;
    logic [PTR_W-1:0] tgt;
    logic [PTR_W-1:0] ptr_nxt;
    logic [LANES-1:0] valid_nxt;

    assign mask_active = mask_q;

    // Scans of the incoming mask: lowest, highest and the lane following the lowest.
    always_comb begin
        in_low  = '0;
        in_high = '0;
        in_any  = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_mask[i]) in_low = PTR_W'(i);
        end
        for (int i = 0; i < LANES; i++) begin
            if (lane_mask[i]) begin
                in_high = PTR_W'(i);
                in_any  = 1'b1;
            end
        end
        in_next = in_low;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (lane_mask[i] && (i > int'(in_low))) in_next = PTR_W'(i);
        end
    end

    always_comb begin
        q_high     = '0;
        q_any      = 1'b0;
        q_next     = '0;
        q_has_next = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            if (mask_q[i]) begin
                q_high = PTR_W'(i);
                q_any  = 1'b1;
            end
        end
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask_q[i] && (i > int'(ptr))) begin
                q_next     = PTR_W'(i);
                q_has_next = 1'b1;
            end
        end
    end

    // Slot selection; sync wins over the normal advance, an empty mask idles and re-samples.
    always_comb begin
        slot_act  = 1'b0;
        tgt       = ptr;
        load_mask = 1'b0;
        ptr_nxt   = ptr;
        rd_nxt    = 1'b0;
        if (sync_in) begin
            slot_act  = in_any;
            tgt       = in_low;
            load_mask = 1'b1;
            ptr_nxt   = in_next;
            rd_nxt    = valid_in && in_any && (in_low == in_high);
        end else if (!q_any) begin
            load_mask = 1'b1;
            ptr_nxt   = in_low;
        end else begin
            slot_act = 1'b1;
            rd_nxt   = valid_in && (ptr == q_high);
            if (q_has_next) begin
                ptr_nxt = q_next;
            end else begin
                load_mask = 1'b1;
                ptr_nxt   = in_low;
            end
        end
    end

    // Lanes dropped by a freshly loaded mask lose their valid on the same edge.
    always_comb begin
        valid_nxt = valid_out;
        if (slot_act) valid_nxt[tgt] = valid_in;
        if (load_mask) valid_nxt = valid_nxt & lane_mask;
    end

    always_ff @(posedge clk_2f) begin
        if (!reset) begin
            lane_data  <= '0;
            valid_out  <= '0;
            round_done <= 1'b0;
            mask_q     <= lane_mask;
            ptr        <= in_low;
        end else begin
            valid_out  <= valid_nxt;
            round_done <= rd_nxt;
            ptr        <= ptr_nxt;
            if (load_mask) mask_q <= lane_mask;
            if (slot_act && valid_in) lane_data[int'(tgt)*DATA_W +: DATA_W] <= data_input;
        end
    end

endmodule

// File: tb/tb_lane_striper_n.sv
// Bench for lane_striper_n (LANES=4): directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a lane-list reference model.
module tb_lane_striper_n;

    localparam int DATA_W = 32;
    localparam int LANES  = 4;

    logic                    clk_2f = 1'b0;
    logic                    reset;
    logic [DATA_W-1:0]       data_input;
    logic                    valid_in;
    logic [LANES-1:0]        lane_mask;
    logic                    sync_in;
    logic [LANES*DATA_W-1:0] lane_data;
    logic [LANES-1:0]        valid_out;
    logic                    round_done;
    logic [LANES-1:0]        mask_active;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] m_data [LANES];
    logic [LANES-1:0]  m_valid;
    logic              m_rd;
    logic [LANES-1:0]  m_mask;
    int                m_ptr;
    bit                m_on = 0;

    lane_striper_n #(.DATA_W(DATA_W), .LANES(LANES)) dut (
        .clk_2f      (clk_2f),
        .reset       (reset),
        .data_input  (data_input),
        .valid_in    (valid_in),
        .lane_mask   (lane_mask),
        .sync_in     (sync_in),
        .lane_data   (lane_data),
        .valid_out   (valid_out),
        .round_done  (round_done),
        .mask_active (mask_active)
    );

    always #5 clk_2f = ~clk_2f;

    function automatic int low_of(input logic [LANES-1:0] m);
        for (int i = 0; i < LANES; i++) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int high_of(input logic [LANES-1:0] m);
        for (int i = LANES - 1; i >= 0; i--) if (m[i]) return i;
        return -1;
    endfunction

    function automatic int next_of(input logic [LANES-1:0] m, input int p);
        for (int i = p + 1; i < LANES; i++) if (m[i]) return i;
        return -1;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference: the slot lane is the pointer into the enabled-lane list of the latched mask.
    task automatic model_step();
        int slot;
        int nx;
        logic [LANES-1:0] eff;
        bit loaded;
        if (!reset) begin
            for (int i = 0; i < LANES; i++) m_data[i] = '0;
            m_valid = '0;
            m_rd    = 1'b0;
            m_mask  = lane_mask;
            m_ptr   = (lane_mask == 0) ? 0 : low_of(lane_mask);
            m_on    = 1;
            return;
        end
        if (!m_on) return;
        slot   = -1;
        eff    = m_mask;
        loaded = 0;
        if (sync_in) begin
            eff  = lane_mask;
            slot = low_of(lane_mask);
        end else if (m_mask != 0) begin
            slot = m_ptr;
        end
        m_rd = 1'b0;
        if (slot >= 0) begin
            if (valid_in) begin
                m_data[slot]  = data_input;
                m_valid[slot] = 1'b1;
                m_rd          = (slot == high_of(eff));
            end else begin
                m_valid[slot] = 1'b0;
            end
        end
        if (sync_in) begin
            loaded = 1;
            if (slot < 0) m_ptr = 0;
            else begin
                nx    = next_of(lane_mask, slot);
                m_ptr = (nx < 0) ? slot : nx;
            end
        end else if (m_mask == 0 || next_of(m_mask, m_ptr) < 0) begin
            loaded = 1;
            m_ptr  = (lane_mask == 0) ? 0 : low_of(lane_mask);
        end else begin
            m_ptr = next_of(m_mask, m_ptr);
        end
        if (loaded) begin
            m_mask  = lane_mask;
            m_valid = m_valid & lane_mask;
        end
    endtask

    task automatic compare_model();
        logic [LANES*DATA_W-1:0] exp_data;
        if (!m_on) return;
        for (int i = 0; i < LANES; i++) exp_data[i*DATA_W +: DATA_W] = m_data[i];
        chk("model_lane_data", 128'(lane_data), 128'(exp_data));
        chk("model_valid_out", 128'(valid_out), 128'(m_valid));
        chk("model_round_done", 128'(round_done), 128'(m_rd));
        chk("model_mask_active", 128'(mask_active), 128'(m_mask));
    endtask

    task automatic cycle();
        @(posedge clk_2f);
        model_step();
        @(negedge clk_2f);
        compare_model();
    endtask

    task automatic drive(input logic r, input logic v, input logic [DATA_W-1:0] d,
                         input logic [LANES-1:0] m, input logic s);
        reset      = r;
        valid_in   = v;
        data_input = d;
        lane_mask  = m;
        sync_in    = s;
        cycle();
    endtask

    initial begin
        logic [LANES-1:0] cur_mask;

        drive(1'b0, 1'b0, '0, 4'hF, 1'b0);
        drive(1'b0, 1'b0, '0, 4'hF, 1'b0);
        chk("reset_lane_data", 128'(lane_data), 128'h0);
        chk("reset_valid_out", 128'(valid_out), 128'h0);
        chk("reset_round_done", 128'(round_done), 128'h0);
        chk("reset_mask_active", 128'(mask_active), 128'hF);

        // Full mask, eight consecutive beats.
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b1, 32'hA0 + 32'(k), 4'hF, 1'b0);
            if (k == 3) begin
                chk("full_round1_data", 128'(lane_data), {32'hA3, 32'hA2, 32'hA1, 32'hA0});
                chk("full_round1_done", 128'(round_done), 128'h1);
            end
            if (k == 4) chk("full_mid_no_done", 128'(round_done), 128'h0);
            if (k == 7) begin
                chk("full_round2_data", 128'(lane_data), {32'hA7, 32'hA6, 32'hA5, 32'hA4});
                chk("full_round2_valid", 128'(valid_out), 128'hF);
                chk("full_round2_done", 128'(round_done), 128'h1);
            end
        end

        // Sparse mask 1010.
        drive(1'b0, 1'b0, '0, 4'b1010, 1'b0);
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b1, 32'h10 + 32'(k), 4'b1010, 1'b0);
            if (k == 0) chk("sparse_first_lane1", 128'(lane_data[63:32]), 128'h10);
            if (k == 1) chk("sparse_done_lane3", 128'(round_done), 128'h1);
            if (k == 3) begin
                chk("sparse_data", 128'(lane_data), {32'h13, 32'h0, 32'h12, 32'h0});
                chk("sparse_valid", 128'(valid_out), 128'b1010);
            end
        end

        // Idle slots for lanes 2 and 3.
        drive(1'b0, 1'b0, '0, 4'hF, 1'b0);
        for (int k = 0; k < 6; k++) drive(1'b1, 1'b1, 32'h20 + 32'(k), 4'hF, 1'b0);
        drive(1'b1, 1'b0, 32'hDEAD, 4'hF, 1'b0);
        chk("idle_valid_drop", 128'(valid_out), 128'b1011);
        chk("idle_lane2_held", 128'(lane_data[95:64]), 128'h22);
        drive(1'b1, 1'b0, 32'hBEEF, 4'hF, 1'b0);
        chk("idle_no_done", 128'(round_done), 128'h0);
        chk("idle_valid_end", 128'(valid_out), 128'b0011);

        // Mask narrows to 0011 mid-round.
        drive(1'b1, 1'b1, 32'h30, 4'hF, 1'b0);
        drive(1'b1, 1'b1, 32'h31, 4'b0011, 1'b0);
        chk("narrow_mask_held", 128'(mask_active), 128'hF);
        drive(1'b1, 1'b1, 32'h32, 4'b0011, 1'b0);
        chk("narrow_lane2_written", 128'(lane_data[95:64]), 128'h32);
        drive(1'b1, 1'b1, 32'h33, 4'b0011, 1'b0);
        chk("narrow_lane3_written", 128'(lane_data[127:96]), 128'h33);
        chk("narrow_mask_loaded", 128'(mask_active), 128'b0011);
        chk("narrow_valid_forced", 128'(valid_out), 128'b0011);
        chk("narrow_done", 128'(round_done), 128'h1);
        drive(1'b1, 1'b1, 32'h34, 4'b0011, 1'b0);
        drive(1'b1, 1'b1, 32'h35, 4'b0011, 1'b0);
        drive(1'b1, 1'b1, 32'h36, 4'b0011, 1'b0);
        chk("narrow_after_data", 128'(lane_data), {32'h33, 32'h32, 32'h35, 32'h36});

        // Sync while the pointer sits on lane 2.
        drive(1'b1, 1'b1, 32'h37, 4'hF, 1'b0);
        drive(1'b1, 1'b1, 32'h38, 4'hF, 1'b0);
        drive(1'b1, 1'b1, 32'h39, 4'hF, 1'b0);
        drive(1'b1, 1'b1, 32'h55, 4'hF, 1'b1);
        chk("sync_lane0", 128'(lane_data[31:0]), 128'h55);
        chk("sync_no_done", 128'(round_done), 128'h0);
        drive(1'b1, 1'b1, 32'h56, 4'hF, 1'b0);
        chk("sync_next_lane1", 128'(lane_data), {32'h33, 32'h32, 32'h56, 32'h55});

        // Reset while the pointer sits on lane 3, with sync and valid also asserted.
        drive(1'b1, 1'b1, 32'h57, 4'hF, 1'b0);
        drive(1'b0, 1'b1, 32'h99, 4'hF, 1'b1);
        chk("midreset_data", 128'(lane_data), 128'h0);
        chk("midreset_valid", 128'(valid_out), 128'h0);
        chk("midreset_done", 128'(round_done), 128'h0);
        drive(1'b1, 1'b1, 32'h60, 4'hF, 1'b0);
        chk("postreset_lane0", 128'(lane_data), {32'h0, 32'h0, 32'h0, 32'h60});
        chk("postreset_valid", 128'(valid_out), 128'b0001);

        // Randomized traffic.
        cur_mask = 4'hF;
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 9) == 0)
                cur_mask = ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom);
            drive(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1,
                  ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
                  $urandom,
                  cur_mask,
                  ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/lane_striper_n.md
LANE_STRIPER_N -- requirements
Module: lane_striper_n

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width in bits of one data word and of each lane.
REQ-002 The block SHALL have parameter LANES, default 4, meaning the number of output lanes; legal values are 2, 4 and 8.
REQ-003 The block SHALL have port clk_2f, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port data_input, input, DATA_W bits: the word to be striped.
REQ-006 The block SHALL have port valid_in, input, 1 bit: qualifies data_input in the current cycle.
REQ-007 The block SHALL have port lane_mask, input, LANES bits: bit i set means lane i is enabled.
REQ-008 The block SHALL have port sync_in, input, 1 bit: restarts striping at the first enabled lane.
REQ-009 The block SHALL have port lane_data, output, LANES*DATA_W bits: lane i occupies bits [i*DATA_W +: DATA_W].
REQ-010 The block SHALL have port valid_out, output, LANES bits: per-lane valid.
REQ-011 The block SHALL have port round_done, output, 1 bit: one-cycle pulse when a valid word is written to the last enabled lane.
REQ-012 The block SHALL have port mask_active, output, LANES bits: the lane mask currently in effect.

Function
REQ-013 The block SHALL keep a registered lane pointer ptr of width clog2(LANES) and a registered mask mask_q; mask_active SHALL equal mask_q.
REQ-014 The block SHALL, on every rising edge out of reset, treat lane ptr as the target slot, whether or not valid_in is high; striping is time-slotted.
REQ-015 The block SHALL, when valid_in=1, load lane_data[ptr] with data_input and set valid_out[ptr]=1 at the next edge, giving a latency of 1 cycle.
REQ-016 The block SHALL, when valid_in=0, clear valid_out[ptr] to 0 and hold lane_data[ptr].
REQ-017 The block SHALL leave lane_data and valid_out of all non-target lanes unchanged in that cycle.
REQ-018 The block SHALL advance ptr each cycle to the next set bit of mask_q above ptr; if there is none, ptr SHALL wrap to the lowest set bit, and this wrap defines the round boundary.
REQ-019 The block SHALL sample lane_mask into mask_q only at a round boundary, at reset, or on sync_in, and never mid-round.
REQ-020 The block SHALL force valid_out[i]=0 and hold lane_data[i] for any lane i cleared in a newly loaded mask_q, starting in the same cycle the mask loads.
REQ-021 The block SHALL, when sync_in=1, write that cycle's beat (if valid) to the lowest set bit of the current lane_mask, load mask_q, and set ptr to the next enabled lane after it.
REQ-022 The block SHALL pulse round_done=1 for exactly the cycle after a valid write to the highest set bit of mask_q; a non-valid slot there SHALL produce no pulse.
REQ-023 The block SHALL, when mask_q is all zeros, perform no writes, hold valid_out at 0 and round_done at 0, keep ptr at 0, and re-sample lane_mask every cycle.
REQ-024 The block SHALL, when mask_q has a single set bit, target that lane every cycle and assert round_done after each valid write.
REQ-025 The block SHALL give sync_in priority over the normal pointer advance when both apply in the same cycle.

Reset
REQ-026 The block SHALL, when reset=0 at a rising edge, clear lane_data, valid_out and round_done to 0, set ptr to the lowest set bit of lane_mask (0 if the mask is zero), and load mask_q from lane_mask.
REQ-027 The block SHALL let reset override sync_in and valid_in; a reset asserted mid-round SHALL discard the partial round without emitting a round_done pulse.
REQ-028 The block SHALL accept its first beat in the first cycle with reset=1.

Verification
REQ-029 The bench SHALL cover: LANES=4, mask=4'b1111, valid words 0xA0..0xA7 on consecutive cycles -> lanes 0..3 receive A0..A3 then A4..A7, valid_out=4'b1111, and round_done pulses after A3 and after A7.
REQ-030 The bench SHALL cover: mask=4'b1010, valid words 0x10..0x13 -> lane1=0x10, lane3=0x11, lane1=0x12, lane3=0x13; lanes 0 and 2 have valid_out=0 and data=0.
REQ-031 The bench SHALL cover: mask=4'b1111 with valid_in=0 in the slot for lane 2 -> valid_out[2] drops to 0, lane2 data is held, and no round_done pulse occurs for that round if lane 3 was also idle.
REQ-032 The bench SHALL cover: mask changed from 4'b1111 to 4'b0011 while ptr=1 -> lanes 2 and 3 still receive the remaining beats of that round, and the new mask takes effect at the next round.
REQ-033 The bench SHALL cover: sync_in=1 with valid word 0x55 while ptr=2 -> lane0=0x55 and the next valid word goes to lane 1.
REQ-034 The bench SHALL cover: reset=0 asserted while ptr=3 -> next cycle all outputs are 0, ptr=0, and the first post-reset word goes to lane 0.
